// File: rtl/imem_program_loader_pkg.sv
// Shared debug-side definitions for the instruction-memory program loader.
package imem_program_loader_pkg;

  localparam int IMEM_BYTES = 256;
  localparam int IMEM_WORDS = IMEM_BYTES / 4;
  localparam int ADDR_W     = 8;

  localparam logic [31:0] HALT_WORD = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RECV  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_e;

endpackage

// File: rtl/imem_program_loader_byte_word_packer.sv
// Packs a big-endian byte stream into 32-bit words; the first byte lands in the MSB.
module byte_word_packer (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        clear_i,
  input  logic        valid_i,
  input  logic [7:0]  byte_i,
  output logic [31:0] word_o,
  output logic [31:0] word_next_o,
  output logic        word_ready_o
);

  logic [31:0] word_q, word_d;
  logic [1:0]  cnt_q, cnt_d;
  logic [31:0] wordShift;

  // A clear that coincides with a valid byte starts the next word with that byte
  always_comb begin
    wordShift    = {word_q[23:0], byte_i};
    word_d       = word_q;
    cnt_d        = cnt_q;
    word_ready_o = 1'b0;
    if (clear_i) begin
      word_d = valid_i ? {24'h0, byte_i} : 32'h0;
      cnt_d  = valid_i ? 2'd1 : 2'd0;
    end else if (valid_i) begin
      word_d       = wordShift;
      cnt_d        = cnt_q + 2'd1;
      word_ready_o = (cnt_q == 2'd3);
    end
  end

  // Shift register and byte counter
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      word_q <= 32'h0;
      cnt_q  <= 2'd0;
    end else begin
      word_q <= word_d;
      cnt_q  <= cnt_d;
    end
  end

  assign word_o      = word_q;
  assign word_next_o = wordShift;

endmodule

// File: rtl/imem_program_loader.sv
// Debug loader: packs UART bytes into words and writes them to sequential imem addresses.
module imem_program_loader
  import imem_program_loader_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_start,
  input  logic        i_rx_valid,
  input  logic [7:0]  i_rx_data,
  output logic        o_write_en,
  output logic [31:0] o_data,
  output logic [31:0] o_addr_wr,
  output logic        o_busy,
  output logic        o_done,
  output logic        o_overflow,
  output logic [6:0]  o_word_count
);

  state_e state_q, state_d;

  logic [ADDR_W:0]   addr_q;
  logic [ADDR_W-1:0] addrWr_q;
  logic [31:0]       data_q;
  logic [6:0]        wordCount_q;
  logic              overflow_q;

  logic [ADDR_W:0] addrNext;
  logic            lastSlot;
  logic            isHalt;
  logic            startAccept;
  logic            packValid;
  logic            packClear;
  logic            wordReady;
  logic [31:0]     packWord;
  logic [31:0]     packWordNext;

  assign addrNext = addr_q + (ADDR_W+1)'(4);
  assign lastSlot = (addrNext == (ADDR_W+1)'(IMEM_BYTES));
  assign isHalt   = (packWord == HALT_WORD);

  byte_word_packer uPacker (
    .clk_i        (i_clk),
    .rst_i        (i_reset),
    .clear_i      (packClear),
    .valid_i      (packValid),
    .byte_i       (i_rx_data),
    .word_o       (packWord),
    .word_next_o  (packWordNext),
    .word_ready_o (wordReady)
  );

  // State register
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // Next-state logic; a session ends on the halt word or after the last slot is written
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (i_start) state_d = RECV;
      RECV:    if (wordReady) state_d = WRITE;
      WRITE:   state_d = (isHalt || lastSlot) ? DONE : RECV;
      DONE:    if (i_start) state_d = RECV;
      default: state_d = IDLE;
    endcase
  end

  // Output and packer control decode; a byte in WRITE is kept only if the session continues
  always_comb begin
    o_write_en  = (state_q == WRITE);
    o_busy      = (state_q == RECV) || (state_q == WRITE);
    o_done      = (state_q == DONE);
    startAccept = i_start && ((state_q == IDLE) || (state_q == DONE));
    packClear   = startAccept || (state_q == WRITE);
    packValid   = i_rx_valid &&
                  ((state_q == RECV) || ((state_q == WRITE) && !isHalt && !lastSlot));
  end

  // Address, word count, overflow flag and the registered write data/address
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      addr_q      <= '0;
      addrWr_q    <= '0;
      data_q      <= 32'h0;
      wordCount_q <= 7'd0;
      overflow_q  <= 1'b0;
    end else begin
      if (startAccept) begin
        addr_q      <= '0;
        wordCount_q <= 7'd0;
        overflow_q  <= 1'b0;
      end
      if ((state_q == RECV) && wordReady) begin
        data_q   <= packWordNext;
        addrWr_q <= addr_q[ADDR_W-1:0];
      end
      if (state_q == WRITE) begin
        addr_q      <= addrNext;
        wordCount_q <= wordCount_q + 7'd1;
        overflow_q  <= !isHalt && lastSlot;
      end
    end
  end

  assign o_data       = data_q;
  assign o_addr_wr    = {{(32-ADDR_W){1'b0}}, addrWr_q};
  assign o_overflow   = overflow_q;
  assign o_word_count = wordCount_q;

endmodule

// File: tb/tb_imem_program_loader.sv
// Directed bench for the imem program loader: halt, overflow, overlap, reset and restart cases.
module tb_imem_program_loader;

  logic        clock;
  logic        reset;
  logic        start;
  logic        rxValid;
  logic [7:0]  rxData;
  logic        writeEn;
  logic [31:0] data;
  logic [31:0] addrWr;
  logic        busy;
  logic        done;
  logic        overflow;
  logic [6:0]  wordCount;

  int vectors    = 0;
  int miscompares = 0;

  logic [31:0] wrData [256];
  logic [31:0] wrAddr [256];
  int          wrCount    = 0;
  int          backToBack = 0;
  logic        prevWe     = 1'b0;
  int          base;

  imem_program_loader dut (
    .i_clk        (clock),
    .i_reset      (reset),
    .i_start      (start),
    .i_rx_valid   (rxValid),
    .i_rx_data    (rxData),
    .o_write_en   (writeEn),
    .o_data       (data),
    .o_addr_wr    (addrWr),
    .o_busy       (busy),
    .o_done       (done),
    .o_overflow   (overflow),
    .o_word_count (wordCount)
  );

  // 10 ns clock
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Log every write strobe away from the active edge and flag back-to-back strobes
  always @(negedge clock) begin
    if (writeEn) begin
      if (prevWe) backToBack++;
      if (wrCount < 256) begin
        wrData[wrCount] = data;
        wrAddr[wrCount] = addrWr;
      end
      wrCount++;
    end
    prevWe = writeEn;
  end

  // One comparison: counts the vector and reports any miscompare
  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Drive one byte for one cycle; called and returns at a falling edge
  task automatic applyStimulus(input logic [7:0] b);
    rxValid = 1'b1;
    rxData  = b;
    @(negedge clock);
    rxValid = 1'b0;
  endtask

  task automatic sendWord(input logic [31:0] w);
    applyStimulus(w[31:24]);
    applyStimulus(w[23:16]);
    applyStimulus(w[15:8]);
    applyStimulus(w[7:0]);
  endtask

  task automatic pulseStart();
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, " write_en"},   writeEn,   0);
    checkOutput({tag, " data"},       data,      0);
    checkOutput({tag, " addr"},       addrWr,    0);
    checkOutput({tag, " busy"},       busy,      0);
    checkOutput({tag, " done"},       done,      0);
    checkOutput({tag, " overflow"},   overflow,  0);
    checkOutput({tag, " word_count"}, wordCount, 0);
  endtask

  initial begin
    reset   = 1'b1;
    start   = 1'b0;
    rxValid = 1'b0;
    rxData  = 8'h00;
    idle(2);
    reset = 1'b0;

    // Reset state and bytes ignored in IDLE
    idle(3);
    checkAllZero("reset");
    sendWord(32'h1234_5678);
    idle(2);
    checkOutput("idle bytes writes", wrCount, 0);
    checkOutput("idle bytes busy", busy, 0);

    // Two-word program ending with the halt word, sent back to back
    pulseStart();
    checkOutput("halt start busy", busy, 1);
    sendWord(32'h2008_0005);
    sendWord(32'hFFFF_FFFF);
    idle(2);
    checkOutput("halt writes", wrCount, 2);
    checkOutput("halt w0 data", wrData[0], 32'h2008_0005);
    checkOutput("halt w0 addr", wrAddr[0], 32'h0);
    checkOutput("halt w1 data", wrData[1], 32'hFFFF_FFFF);
    checkOutput("halt w1 addr", wrAddr[1], 32'h4);
    checkOutput("halt done", done, 1);
    checkOutput("halt busy", busy, 0);
    checkOutput("halt overflow", overflow, 0);
    checkOutput("halt word_count", wordCount, 2);
    checkOutput("halt hold data", data, 32'hFFFF_FFFF);
    checkOutput("halt hold addr", addrWr, 32'h4);
    sendWord(32'h0102_0304);
    idle(2);
    checkOutput("done bytes writes", wrCount, 2);

    // Fill memory with 64 zero words and no halt word
    base = wrCount;
    pulseStart();
    checkOutput("fill start done", done, 0);
    checkOutput("fill start word_count", wordCount, 0);
    sendWord(32'h0);
    checkOutput("fill latency write_en", writeEn, 1);
    checkOutput("fill latency addr", addrWr, 0);
    idle(1);
    checkOutput("fill single strobe", writeEn, 0);
    checkOutput("fill busy between words", busy, 1);
    for (int i = 1; i < 64; i++) sendWord(32'h0);
    idle(2);
    checkOutput("fill writes", wrCount - base, 64);
    for (int i = 0; i < 64; i++) begin
      checkOutput($sformatf("fill addr %0d", i), wrAddr[base + i], 32'(i * 4));
      checkOutput($sformatf("fill data %0d", i), wrData[base + i], 32'h0);
    end
    checkOutput("fill done", done, 1);
    checkOutput("fill overflow", overflow, 1);
    checkOutput("fill word_count", wordCount, 64);
    sendWord(32'h0);
    idle(2);
    checkOutput("fill 65th word writes", wrCount - base, 64);

    // Restart from DONE; byte arriving during WRITE must start the next word
    base = wrCount;
    pulseStart();
    checkOutput("overlap start done", done, 0);
    checkOutput("overlap start overflow", overflow, 0);
    checkOutput("overlap start word_count", wordCount, 0);
    sendWord(32'h1122_3344);
    sendWord(32'hAABB_CCDD);
    sendWord(32'hFFFF_FFFF);
    idle(2);
    checkOutput("overlap writes", wrCount - base, 3);
    checkOutput("overlap w0 data", wrData[base], 32'h1122_3344);
    checkOutput("overlap w1 data", wrData[base + 1], 32'hAABB_CCDD);
    checkOutput("overlap w1 addr", wrAddr[base + 1], 32'h4);
    checkOutput("overlap w2 addr", wrAddr[base + 2], 32'h8);
    checkOutput("overlap word_count", wordCount, 3);

    // Start mid-word is ignored, then reset mid-word clears everything
    base = wrCount;
    pulseStart();
    applyStimulus(8'h01);
    applyStimulus(8'h02);
    pulseStart();
    checkOutput("midstart busy", busy, 1);
    applyStimulus(8'h03);
    applyStimulus(8'h04);
    idle(1);
    checkOutput("midstart writes", wrCount - base, 1);
    checkOutput("midstart w0 data", wrData[base], 32'h0102_0304);
    checkOutput("midstart w0 addr", wrAddr[base], 32'h0);
    applyStimulus(8'h55);
    applyStimulus(8'h66);
    reset = 1'b1;
    #1;
    checkAllZero("midreset");
    idle(1);
    reset = 1'b0;
    idle(1);
    base = wrCount;
    pulseStart();
    sendWord(32'hDEAD_BEEF);
    sendWord(32'hFFFF_FFFF);
    idle(2);
    checkOutput("postreset writes", wrCount - base, 2);
    checkOutput("postreset w0 data", wrData[base], 32'hDEAD_BEEF);
    checkOutput("postreset w0 addr", wrAddr[base], 32'h0);
    checkOutput("postreset w1 addr", wrAddr[base + 1], 32'h4);
    checkOutput("postreset word_count", wordCount, 2);
    checkOutput("single-cycle strobes", backToBack, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/imem_program_loader.md
Name: imem_program_loader

Overview:
- Debug-side writer for the instruction-memory write port of the fetch stage.
- Takes a byte stream from the debug UART receiver and packs each 4 bytes into a 32-bit instruction word.
- Issues single-cycle writes to sequential word addresses.
- Stops on the HALT word or when instruction memory is full, then reports completion to the debug unit.

Parameters:
- IMEM_BYTES, 256, instruction memory size in bytes; the write address space is 8 bits wide.
- HALT_WORD, 32'hFFFFFFFF, end-of-program marker; it is written to memory, then loading stops.

Ports:
- i_clk  input  1  system clock, rising edge.
- i_reset  input  1  asynchronous, active-high reset.
- i_start  input  1  one-cycle pulse that begins a load session.
- i_rx_valid  input  1  one-cycle strobe; i_rx_data holds a valid byte.
- i_rx_data  input  8  received byte.
- o_write_en  output  1  instruction-memory write strobe.
- o_data  output  32  word to write.
- o_addr_wr  output  32  byte address of the write; bits [1:0] are always 0 and bits [31:8] are always 0.
- o_busy  output  1  high while a session is active (RECV or WRITE).
- o_done  output  1  high in DONE state.
- o_overflow  output  1  memory filled without HALT_WORD; valid while o_done is high.
- o_word_count  output  7  number of words written in the current or last session (0..64).

Behaviour:
- Reset (async): state IDLE. Every output is 0. Byte counter, shift register and address are all 0.
- States: IDLE, RECV, WRITE, DONE.
- IDLE:
  - i_rx_valid is ignored.
  - i_start -> RECV; clear address, byte count, word count and o_overflow.
- RECV: on i_rx_valid, shift in the byte: word <= {word[23:0], i_rx_data}. The first byte received is the MSB (big-endian).
- After the 4th byte, go to WRITE on the next edge.
- WRITE: lasts exactly 1 cycle.
  - o_write_en = 1, o_data = assembled word, o_addr_wr = current address.
  - Next edge: address += 4, o_word_count += 1, byte count cleared.
  - If word == HALT_WORD -> DONE, o_overflow = 0.
  - Else, if the new address == IMEM_BYTES (the 64th word was just written) -> DONE, o_overflow = 1.
  - Otherwise -> RECV.
- i_rx_valid during WRITE: the byte is captured as byte 0 of the next word. It is not dropped. If WRITE exits to DONE, the byte is discarded.
- DONE:
  - o_done held high.
  - Extra i_rx_valid bytes are ignored.
  - i_start -> RECV with the fresh-session clears.
- i_start while o_busy is high is ignored. It never restarts a session mid-word.
- Write latency: o_write_en asserts in the cycle after the edge that captures the 4th byte.
- o_write_en is never high for more than 1 consecutive cycle, and never outside WRITE.
- Address wrap: never occurs. The session terminates before the address would exceed IMEM_BYTES-4.
- Reset mid-session: immediate return to IDLE. Words already written stay in memory; the loader does not roll them back.
- o_data and o_addr_wr are registered and hold their last values outside WRITE; only o_write_en qualifies them.

Decomposition:
- Shared debug package holds:
  - the state enum (IDLE/RECV/WRITE/DONE);
  - HALT_WORD;
  - IMEM_BYTES and the derived IMEM_WORDS = IMEM_BYTES/4;
  - the address width of 8.
- One sub-module, byte_word_packer, holds the 32-bit shift register and 2-bit byte counter. Its interface is byte in, valid, clear, word_ready out.
- The FSM, address counter and word counter stay in imem_program_loader.

Test Plan:
- Reset, then 3 cycles idle -> all outputs 0. Bytes sent while in IDLE produce no o_write_en.
- i_start, then bytes 20,08,00,05, then FF,FF,FF,FF ->
  - write 32'h20080005 at addr 0;
  - write 32'hFFFFFFFF at addr 4;
  - o_done=1, o_overflow=0, o_word_count=2.
- i_start, then 64 words of 32'h00000000 (no HALT) ->
  - 64 writes, addresses 0..252 in steps of 4;
  - o_done=1, o_overflow=1, o_word_count=64;
  - a 65th word's bytes produce no write.
- 4th byte of word 0 followed by the first byte 8'hAA of word 1 in the WRITE cycle -> word 1 is 32'hAAxxxxxx and is written at addr 4; no byte is lost.
- Reset asserted after 2 bytes of word 1 -> immediate IDLE with all outputs 0. A new i_start loads from addr 0.
- i_start pulsed again mid-word and again in DONE ->
  - mid-word: ignored, and the word completes normally;
  - in DONE: new session, o_word_count cleared to 0, o_done deasserted.
